// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: FSM state encoding, default slice depth
// and the lane-counter width helper.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEPTH_DEFAULT = 225;

  // A one-lane row still needs a 1-bit counter so the port never collapses to zero width.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Valid/ready weight-word stream between the host/DMA side (master) and the loader (slave).
interface weight_loader_if #(
  parameter int Ndata = 24
);
  logic [Ndata-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/weight_loader_row_packer.sv
// N-lane register file that collects one weight word per lane and presents the flat row bus.
module row_packer
  import weight_loader_pkg::*;
#(
  parameter int N     = 40,
  parameter int Ndata = 24,
  parameter int LW    = lane_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [LW-1:0]        idx,
  input  logic [Ndata-1:0]     din,
  output logic [Ndata*N-1:0]   wdata
);

  logic [Ndata-1:0] lanes [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) lanes[k] <= '0;
    end else if (we) begin
      for (int k = 0; k < N; k++) begin
        if (idx == LW'(k)) lanes[k] <= din;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign wdata[Ndata*k +: Ndata] = lanes[k];
  end

endmodule

// File: rtl/weight_loader.sv
// Write-side sequencer: packs N streamed words per row and writes DEPTH rows of one slice.
// Optional running checksum output enabled by defining WLOAD_CKSUM_EN.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int N     = 40,
  parameter int Ndata = 24,
  parameter int Naddr = 9,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           slc,
  weight_loader_if.slave       stream,
  output logic [Ndata*N-1:0]   wdata,
  output logic [Naddr-2:0]     wraddr,
  output logic [1:0]           wrslc,
  output logic                 wren,
  output logic                 busy,
  output logic                 done
`ifdef WLOAD_CKSUM_EN
  ,
  output logic [Ndata-1:0]     cksum
`endif
);

  localparam int LW = lane_w(N);
  localparam int RW = Naddr - 1;

  state_t          state;
  state_t          state_nxt;
  logic [LW-1:0]   lane_cnt;
  logic [RW-1:0]   row_cnt;
  logic            hs;
  logic            lane_last;
  logic            row_last;

  assign hs        = stream.in_valid & stream.in_ready;
  assign lane_last = (lane_cnt == LW'(N - 1));
  assign row_last  = (row_cnt == RW'(DEPTH - 1));
  assign wraddr    = row_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (hs && lane_last) state_nxt = WRITE;
      WRITE:   state_nxt = row_last ? DONE : FILL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stream.in_ready = 1'b0;
    wren            = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      FILL:    stream.in_ready = 1'b1;
      WRITE:   wren = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Slice is only captured from IDLE, so a start pulse mid-load cannot retarget the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt <= '0;
      row_cnt  <= '0;
      wrslc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wrslc    <= slc;
            lane_cnt <= '0;
            row_cnt  <= '0;
          end
        end
        FILL: begin
          if (hs) lane_cnt <= lane_last ? '0 : lane_cnt + LW'(1);
        end
        WRITE: begin
          if (!row_last) row_cnt <= row_cnt + RW'(1);
        end
        default: ;
      endcase
    end
  end

  row_packer #(
    .N     (N),
    .Ndata (Ndata),
    .LW    (LW)
  ) u_row_packer (
    .clk   (clk),
    .rst   (rst),
    .we    (hs),
    .idx   (lane_cnt),
    .din   (stream.in_data),
    .wdata (wdata)
  );

`ifdef WLOAD_CKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cksum <= '0;
    else if (state == IDLE && start) cksum <= '0;
    else if (hs)                    cksum <= cksum + stream.in_data;
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: reset/start vector table, full-slice loads with
// a word-list reference model, ignored start, async reset mid-row and (with WLOAD_CKSUM_EN) checksum.
module tb_weight_loader;

  localparam int N      = 40;
  localparam int NDATA  = 24;
  localparam int NADDR  = 9;
  localparam int DEPTH  = 225;
  localparam int TOTAL  = N * DEPTH;
  localparam int BUDGET = 60000;

  logic                 clk   = 1'b0;
  logic                 rst   = 1'b0;
  logic                 start = 1'b0;
  logic [1:0]           slc   = 2'd0;
  logic [NDATA*N-1:0]   wdata;
  logic [NADDR-2:0]     wraddr;
  logic [1:0]           wrslc;
  logic                 wren;
  logic                 busy;
  logic                 done;
`ifdef WLOAD_CKSUM_EN
  logic [NDATA-1:0]     cksum;
`endif

  weight_loader_if #(.Ndata(NDATA)) stream ();

  weight_loader #(
    .N     (N),
    .Ndata (NDATA),
    .Naddr (NADDR),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .slc    (slc),
    .stream (stream),
    .wdata  (wdata),
    .wraddr (wraddr),
    .wrslc  (wrslc),
    .wren   (wren),
    .busy   (busy),
    .done   (done)
`ifdef WLOAD_CKSUM_EN
    ,
    .cksum  (cksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_v;
    logic       start_v;
    logic [1:0] slc_v;
    logic       valid_v;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_wren;
    logic       exp_done;
    logic [1:0] exp_wrslc;
    logic [7:0] exp_wraddr;
  } vec_t;

  vec_t tbl [10];

  // One slice load driven from a generated word list; rows are checked against that list.
  // mode: 0 = word index, 1 = random, 2 = all ones. stop_at >= 0 returns once that many
  // words are accepted; bad_at >= 0 pulses a start with slc=1 after that many words.
  task automatic run_load(input logic [1:0] s, input int gap_max, input int mode,
                          input int stop_at, input int bad_at, input int exp_done_cyc);
    logic [NDATA-1:0] src [];
`ifdef WLOAD_CKSUM_EN
    logic [NDATA-1:0] sum;
`endif
    int  sent, rows, gap, ncyc, done_cnt, done_cyc, mism;
    bit  bad_pending, bad_done;
    src = new[TOTAL];
    foreach (src[i]) begin
      if (mode == 0)      src[i] = NDATA'(i);
      else if (mode == 1) src[i] = NDATA'($urandom);
      else                src[i] = {NDATA{1'b1}};
    end
`ifdef WLOAD_CKSUM_EN
    sum = '0;
`endif
    sent = 0; rows = 0; gap = 0; ncyc = 0; done_cnt = 0; done_cyc = -1;
    bad_pending = 1'b0; bad_done = 1'b0;
    @(negedge clk);
    start = 1'b1; slc = s; stream.in_valid = 1'b0;
    while (ncyc < BUDGET) begin
      @(negedge clk);
      ncyc++;
      start = 1'b0; slc = s;
      if (bad_pending) begin
        chk("ignored_start_wrslc", wrslc, s);
        chk("ignored_start_fill", {busy, stream.in_ready}, 2'b11);
        bad_pending = 1'b0;
      end
      if (wren) begin
        chk("wraddr", wraddr, rows);
        chk("wrslc", wrslc, s);
        chk("ready_in_write", stream.in_ready, 1'b0);
        chk("words_per_row", sent, N * (rows + 1));
        chk("wren_row_in_range", rows < DEPTH, 1'b1);
        if (rows < DEPTH) begin
          mism = 0;
          for (int k = 0; k < N; k++)
            if (wdata[NDATA*k +: NDATA] !== src[N*rows + k]) mism++;
          chk("row_lanes", mism, 0);
        end
        rows++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = ncyc;
        chk("done_rows", rows, DEPTH);
        chk("done_wraddr", wraddr, DEPTH - 1);
        chk("ready_in_done", stream.in_ready, 1'b0);
`ifdef WLOAD_CKSUM_EN
        chk("cksum_done", cksum, sum);
`endif
      end
      if (done_cyc >= 0 && ncyc > done_cyc) begin
        chk("idle_after_done", {busy, stream.in_ready, done, wren}, 4'b0);
`ifdef WLOAD_CKSUM_EN
        chk("cksum_stable", cksum, sum);
`endif
      end
      if (done_cyc >= 0 && ncyc >= done_cyc + 3) break;
      if (stop_at >= 0 && sent == stop_at) break;
      if (bad_at >= 0 && !bad_done && sent == bad_at && stream.in_ready) begin
        start = 1'b1; slc = 2'd1; bad_done = 1'b1; bad_pending = 1'b1;
      end
      if (sent < TOTAL) begin
        if (gap > 0) begin
          stream.in_valid = 1'b0;
          gap--;
        end else begin
          stream.in_valid = 1'b1;
          stream.in_data  = src[sent];
        end
      end else begin
        stream.in_valid = 1'b0;
      end
      if (stream.in_valid && stream.in_ready) begin
`ifdef WLOAD_CKSUM_EN
        sum += src[sent];
`endif
        sent++;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      end
    end
    if (stop_at < 0) begin
      chk("done_seen", done_cyc >= 0, 1'b1);
      chk("done_pulses", done_cnt, 1);
      chk("rows_written", rows, DEPTH);
      if (exp_done_cyc > 0) chk("done_latency", done_cyc, exp_done_cyc);
      stream.in_valid = 1'b0;
    end else begin
      chk("stop_reached", sent, stop_at);
    end
  endtask

  initial begin
    int bad;
    stream.in_valid = 1'b0;
    stream.in_data  = '0;

    //                rst start slc vld  rdy busy wren done wrslc wraddr
    tbl[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[2] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0};
    tbl[3] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0};
    tbl[4] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[6] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[7] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0};
    tbl[8] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[9] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst_v; start = tbl[i].start_v; slc = tbl[i].slc_v;
      stream.in_valid = tbl[i].valid_v;
      stream.in_data  = NDATA'(24'h5A5A50 + i);
      @(negedge clk);
      chk($sformatf("vec%0d_outputs", i),
          {stream.in_ready, busy, wren, done, wrslc, wraddr},
          {tbl[i].exp_ready, tbl[i].exp_busy, tbl[i].exp_wren, tbl[i].exp_done,
           tbl[i].exp_wrslc, tbl[i].exp_wraddr});
      if (!tbl[i].rst_v) begin
        chk($sformatf("vec%0d_wdata_zero", i), wdata == '0, 1'b1);
`ifdef WLOAD_CKSUM_EN
        chk($sformatf("vec%0d_cksum_zero", i), cksum, 0);
`endif
      end
    end
    start = 1'b0; stream.in_valid = 1'b0;

    // slc=2 load with an ignored start, then async reset at lane 17 of row 100
    run_load(2'd2, 0, 1, 100 * N + 17, 5, -1);
    chk("fill_before_reset", {busy, stream.in_ready, wren}, 3'b110);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_ctrl", {stream.in_ready, busy, wren, done, wrslc, wraddr}, 0);
    chk("async_reset_wdata", wdata == '0, 1'b1);
`ifdef WLOAD_CKSUM_EN
    chk("async_reset_cksum", cksum, 0);
`endif
    stream.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      stream.in_data = NDATA'($urandom);
      @(negedge clk);
      if (wren || done || busy || stream.in_ready) bad++;
    end
    chk("quiet_after_reset", bad, 0);
    stream.in_valid = 1'b0;

    // fresh ungapped slice from wraddr 0: words 0..8999, done latency
    run_load(2'd0, 0, 0, -1, -1, 9226);
    // gapped random slice on slice 3
    run_load(2'd3, 5, 1, -1, -1, -1);

`ifdef WLOAD_CKSUM_EN
    run_load(2'd1, 0, 2, -1, -1, 9226);
    chk("cksum_all_ones", cksum, 24'hFFDCD8);
    @(negedge clk);
    start = 1'b1; slc = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk("cksum_cleared_on_start", cksum, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
